fetch_unit: RTL

- Instruction-fetch stage that owns the program counter and drives the address of the word-addressed, combinational instruction memory.
- Captures the returned instruction word and presents instruction, PC and PC+4 to decode through a valid/ready output register.
- Handles control-flow redirects from execute, and flags misaligned or out-of-range fetches.
- Keeps a count of delivered instructions for bring-up and performance checks.

---
 rtl/fetch_unit_if.sv | 46 ++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, its instruction memory, execute
// (redirects) and decode (valid/ready output register).
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_exc;
    logic [1:0]  if_exc_cause;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_target,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_pc_plus4,
        output if_exc,
        output if_exc_cause,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_target,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4,
        input  if_exc,
        input  if_exc_cause,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers fetched words for decode,
// handles redirects and halts on misaligned or out-of-range fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [1:0]  CAUSE_NONE      = 2'b00;
    localparam logic [1:0]  CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE     = 2'b10;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        exc_q, exc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] count_q, count_d;

    logic        load;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] pc_plus4;

    assign pc_plus4     = pc_q + 32'd4;
    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign out_of_range = ({2'b00, pc_q[31:2]} >= IMEM_DEPTH);

    // NOTE: every variable gets a hold/default value before any branch so
    // no path through the block leaves it unassigned (no latch inferred).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        count_d = count_q;

        load = (!valid_q || bus.if_ready) && (state_q == ST_RUN) && !bus.redirect_valid;

        if (valid_q && bus.if_ready && !bus.redirect_valid) begin
            count_d = count_q + 32'd1;
        end

        if (bus.redirect_valid) begin
            // Squash whatever is in the output register; one bubble follows.
            pc_d    = bus.redirect_target;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (load) begin
            valid_d = 1'b1;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
            if (misaligned || out_of_range) begin
                instr_d = NOP_INSTR;
                exc_d   = 1'b1;
                cause_d = misaligned ? CAUSE_MISALIGN : CAUSE_RANGE;
                state_d = ST_HALT;
            end else begin
                instr_d = bus.imem_rdata;
                exc_d   = 1'b0;
                cause_d = CAUSE_NONE;
                pc_d    = pc_plus4;
            end
        end else if (valid_q && bus.if_ready) begin
            // Halted: the fault entry drains and nothing replaces it.
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'h0;
            ipc4_q  <= 32'h0;
            exc_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.if_valid     = valid_q;
    assign bus.if_instr     = instr_q;
    assign bus.if_pc        = ipc_q;
    assign bus.if_pc_plus4  = ipc4_q;
    assign bus.if_exc       = exc_q;
    assign bus.if_exc_cause = cause_q;
    assign bus.fetch_count  = count_q;

endmodule
